// File: rtl/uart_tx_sched_pkg.sv
// Shared types and sizing helpers for the UART TX round-robin scheduler.
package uart_tx_sched_pkg;

    localparam int DEF_NUM_REQ     = 2;
    localparam int DEF_BYTE_W      = 8;
    localparam int DEF_MAX_BYTES   = 2;
    localparam int DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_e;

    // Width of a byte counter able to hold 0..max_bytes.
    function automatic int len_width(input int max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Stateless round-robin pick: first active request above the pointer, wrapping.
module uart_tx_sched_rr_arbiter
    import uart_tx_sched_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    int               w_cand;
    logic [IDX_W-1:0] w_cand_idx;
    logic             w_hit;

    // Scan candidates in priority order starting just above the pointer.
    always_comb begin
        o_gnt      = {NUM_REQ{1'b0}};
        o_idx      = {IDX_W{1'b0}};
        o_any      = 1'b0;
        w_cand     = 0;
        w_cand_idx = {IDX_W{1'b0}};
        w_hit      = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_cand     = int'(i_ptr) + off;
            w_cand     = (w_cand >= NUM_REQ) ? (w_cand - NUM_REQ) : w_cand;
            w_cand_idx = w_cand[IDX_W-1:0];
            w_hit      = !o_any && i_req[w_cand_idx];
            o_gnt[w_cand_idx] = o_gnt[w_cand_idx] | w_hit;
            o_idx      = w_hit ? w_cand_idx : o_idx;
            o_any      = o_any | w_hit;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin frame scheduler in front of a single UART transmitter.
// Optional WAIT_BUSY watchdog enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter  int NUM_REQ     = DEF_NUM_REQ,
    parameter  int BYTE_W      = DEF_BYTE_W,
    parameter  int MAX_BYTES   = DEF_MAX_BYTES,
    parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int LEN_W       = len_width(MAX_BYTES),
    localparam int IDX_W       = idx_width(NUM_REQ),
    localparam int FRAME_W     = MAX_BYTES * BYTE_W
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*FRAME_W-1:0] req_data,
    input  logic [NUM_REQ*LEN_W-1:0]   req_len,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [BYTE_W-1:0]          tx_p_data,
    output logic                       tx_data_valid,
    input  logic                       tx_busy,
    output logic                       sched_busy,
    output logic                       frame_done,
    output logic                       err_timeout
);

    sched_state_e       r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [FRAME_W-1:0] r_shift;
    logic [LEN_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [BYTE_W-1:0]  r_pdata;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [IDX_W-1:0]   w_arb_idx;
    logic               w_arb_any;
    logic [FRAME_W-1:0] w_frame;
    logic [LEN_W-1:0]   w_len_raw;
    logic [LEN_W-1:0]   w_len;
    logic               w_start;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [WD_W-1:0]    r_wdog;
`else
    logic               w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC > 0);
`endif

    uart_tx_sched_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    // Route the winning requester's payload and length to the capture path.
    always_comb begin
        w_frame   = {FRAME_W{1'b0}};
        w_len_raw = {LEN_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            w_frame   = (w_arb_idx == IDX_W'(i)) ? req_data[i*FRAME_W +: FRAME_W] : w_frame;
            w_len_raw = (w_arb_idx == IDX_W'(i)) ? req_len[i*LEN_W +: LEN_W] : w_len_raw;
        end
    end

    assign w_len   = (w_len_raw > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : w_len_raw;
    // Holding off for the frame_done cycle guarantees an idle gap between frames
    // and stops a zero-length requester from being re-granted before it drops req.
    assign w_start = (r_state == IDLE) && w_arb_any && !r_done;

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_ptr   <= IDX_W'(NUM_REQ - 1);
            r_shift <= {FRAME_W{1'b0}};
            r_cnt   <= {LEN_W{1'b0}};
            r_gnt   <= {NUM_REQ{1'b0}};
            r_pdata <= {BYTE_W{1'b0}};
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            r_wdog  <= {WD_W{1'b0}};
`endif
        end else begin
            r_gnt   <= {NUM_REQ{1'b0}};
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_gnt   <= w_arb_gnt;
                        r_ptr   <= w_arb_idx;
                        r_shift <= w_frame >> BYTE_W;
                        r_cnt   <= w_len;
                        if (w_len == LEN_W'(0)) begin
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_pdata <= w_frame[BYTE_W-1:0];
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= SEND;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SEND: begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    r_wdog  <= {WD_W{1'b0}};
`endif
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= WAIT_DONE;
                    end else begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
                        // Transmitter never took the byte: offer it again.
                        if (r_wdog == WD_W'(TIMEOUT_CYC - 1)) begin
                            r_valid <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= SEND;
                        end else begin
                            r_wdog  <= r_wdog + WD_W'(1);
                            r_state <= WAIT_BUSY;
                        end
`else
                        r_state <= WAIT_BUSY;
`endif
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (r_cnt > LEN_W'(1)) begin
                            r_pdata <= r_shift[BYTE_W-1:0];
                            r_shift <= r_shift >> BYTE_W;
                            r_cnt   <= r_cnt - LEN_W'(1);
                            r_valid <= 1'b1;
                            r_state <= SEND;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_state <= WAIT_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt           = r_gnt;
    assign tx_p_data     = r_pdata;
    assign tx_data_valid = r_valid;
    assign sched_busy    = r_busy;
    assign frame_done    = r_done;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    assign err_timeout   = r_err;
`else
    assign err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched (NUM_REQ=2, MAX_BYTES=2, TIMEOUT_CYC=16).
module tb_uart_tx_sched;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_len;
    logic [1:0]  gnt;
    logic [7:0]  tx_p_data;
    logic        tx_data_valid;
    logic        tx_busy;
    logic        sched_busy;
    logic        frame_done;
    logic        err_timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] byte_q[$];
    int         valid_cyc_q[$];
    logic [1:0] gnt_q[$];
    int         gnt_cyc_q[$];
    int         n_done;

    bit resp_en;
    bit drop_on_gnt;
    int resp_dly;
    int resp_hold;

    always #5 CLK = ~CLK;

    uart_tx_sched #(
        .NUM_REQ     (2),
        .BYTE_W      (8),
        .MAX_BYTES   (2),
        .TIMEOUT_CYC (16)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .req           (req),
        .req_data      (req_data),
        .req_len       (req_len),
        .gnt           (gnt),
        .tx_p_data     (tx_p_data),
        .tx_data_valid (tx_data_valid),
        .tx_busy       (tx_busy),
        .sched_busy    (sched_busy),
        .frame_done    (frame_done),
        .err_timeout   (err_timeout)
    );

    // One clock: observe outputs 1ns after the edge, then play requester and transmitter.
    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        if (tx_data_valid === 1'b1) begin
            byte_q.push_back(tx_p_data);
            valid_cyc_q.push_back(cyc);
        end
        if (gnt !== 2'b00) begin
            gnt_q.push_back(gnt);
            gnt_cyc_q.push_back(cyc);
            if (drop_on_gnt) req = req & ~gnt;
        end
        if (frame_done === 1'b1) n_done++;
        if (resp_en) begin
            if (resp_dly > 0) resp_dly--;
            if (resp_dly == 0) begin
                resp_hold = 10;
                resp_dly  = -1;
            end
            if (tx_data_valid === 1'b1) resp_dly = 2;
            tx_busy = (resp_hold > 0);
            if (resp_hold > 0) resp_hold--;
        end
    endtask

    task automatic clear_logs();
        byte_q.delete();
        valid_cyc_q.delete();
        gnt_q.delete();
        gnt_cyc_q.delete();
        n_done = 0;
    endtask

    task automatic do_reset();
        RST         = 1'b1;
        req         = 2'b00;
        req_data    = 32'h0;
        req_len     = 4'h0;
        tx_busy     = 1'b0;
        resp_en     = 1'b0;
        drop_on_gnt = 1'b1;
        resp_dly    = -1;
        resp_hold   = 0;
        step();
        step();
        RST = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        total++; if (tx_data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", tx_data_valid); end
        total++; if (tx_p_data !== 8'h00) begin bad++; $display("FAIL reset_pdata: got %h want 00", tx_p_data); end
        total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", sched_busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", frame_done); end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_timeout); end
    endtask

    task automatic test_single_frame();
        int t0;
        do_reset();
        resp_en  = 1'b1;
        req_data = {16'h0000, 16'hA55A};
        req_len  = {2'd0, 2'd2};
        req      = 2'b01;
        t0       = cyc;
        for (int i = 0; i < 100 && n_done < 1; i++) step();
        total++; if (n_done != 1) begin bad++; $display("FAIL single_done: got %0d want 1", n_done); end
        total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b want 0", sched_busy); end
        total++; if (gnt_q.size() != 1 || gnt_q[0] !== 2'b01) begin bad++; $display("FAIL single_gnt: got n=%0d want one 01", gnt_q.size()); end
        total++; if (gnt_q.size() < 1 || gnt_cyc_q[0] != t0 + 1) begin bad++; $display("FAIL single_gnt_latency: got n=%0d want cycle %0d", gnt_q.size(), t0 + 1); end
        total++; if (byte_q.size() != 2) begin bad++; $display("FAIL single_nbytes: got %0d want 2", byte_q.size()); end
        if (byte_q.size() == 2) begin
            total++; if (byte_q[0] !== 8'h5A) begin bad++; $display("FAIL single_byte0: got %h want 5a", byte_q[0]); end
            total++; if (byte_q[1] !== 8'hA5) begin bad++; $display("FAIL single_byte1: got %h want a5", byte_q[1]); end
            total++; if (valid_cyc_q[0] != t0 + 1) begin bad++; $display("FAIL single_valid_latency: got %0d want %0d", valid_cyc_q[0], t0 + 1); end
        end
        for (int i = 0; i < 5; i++) step();
        total++; if (n_done != 1) begin bad++; $display("FAIL single_done_once: got %0d want 1", n_done); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        logic [7:0] exp_b;
        do_reset();
        resp_en     = 1'b1;
        drop_on_gnt = 1'b0;
        req_data    = {16'h00B2, 16'h00B1};
        req_len     = {2'd1, 2'd1};
        req         = 2'b11;
        for (int i = 0; i < 400 && gnt_q.size() < 4; i++) begin
            step();
            if (gnt_q.size() >= 4) req = 2'b00;
        end
        req = 2'b00;
        for (int i = 0; i < 100 && (n_done < gnt_q.size() || sched_busy !== 1'b0); i++) step();
        total++; if (gnt_q.size() != 4) begin bad++; $display("FAIL rr_ngnt: got %0d want 4", gnt_q.size()); end
        total++; if (n_done != gnt_q.size()) begin bad++; $display("FAIL rr_done_count: got %0d want %0d", n_done, gnt_q.size()); end
        for (int i = 0; i < 4 && i < gnt_q.size(); i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            total++; if (gnt_q[i] !== exp_g) begin bad++; $display("FAIL rr_gnt%0d: got %b want %b", i, gnt_q[i], exp_g); end
        end
        for (int i = 0; i < 4 && i < byte_q.size(); i++) begin
            exp_b = (i % 2 == 0) ? 8'hB1 : 8'hB2;
            total++; if (byte_q[i] !== exp_b) begin bad++; $display("FAIL rr_byte%0d: got %h want %h", i, byte_q[i], exp_b); end
        end
    endtask

    task automatic test_zero_len();
        do_reset();
        req_data = {16'h7777, 16'h0000};
        req_len  = {2'd0, 2'd0};
        req      = 2'b10;
        step();
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL zero_gnt: got %b want 10", gnt); end
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL zero_done_same_cycle: got %b want 1", frame_done); end
        total++; if (tx_data_valid !== 1'b0) begin bad++; $display("FAIL zero_valid: got %b want 0", tx_data_valid); end
        total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL zero_busy: got %b want 0", sched_busy); end
        for (int i = 0; i < 8; i++) step();
        total++; if (byte_q.size() != 0) begin bad++; $display("FAIL zero_nbytes: got %0d want 0", byte_q.size()); end
        total++; if (gnt_q.size() != 1) begin bad++; $display("FAIL zero_ngnt: got %0d want 1", gnt_q.size()); end
        total++; if (n_done != 1) begin bad++; $display("FAIL zero_ndone: got %0d want 1", n_done); end
    endtask

    task automatic test_pre_busy();
        do_reset();
        tx_busy  = 1'b1;
        req_data = {16'h0000, 16'h0077};
        req_len  = {2'd0, 2'd1};
        req      = 2'b01;
        for (int i = 0; i < 10; i++) step();
        total++; if (byte_q.size() != 1) begin bad++; $display("FAIL prebusy_nbytes_hold: got %0d want 1", byte_q.size()); end
        total++; if (n_done != 0 || sched_busy !== 1'b1) begin bad++; $display("FAIL prebusy_waiting: got done=%0d busy=%b want 0/1", n_done, sched_busy); end
        tx_busy = 1'b0;
        for (int i = 0; i < 10 && n_done < 1; i++) step();
        total++; if (n_done != 1) begin bad++; $display("FAIL prebusy_done: got %0d want 1", n_done); end
        total++; if (byte_q.size() != 1) begin bad++; $display("FAIL prebusy_no_repulse: got %0d want 1", byte_q.size()); end
        total++; if (byte_q.size() >= 1 && byte_q[0] !== 8'h77) begin bad++; $display("FAIL prebusy_byte: got %h want 77", byte_q[0]); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        resp_en  = 1'b1;
        req_data = {16'h0000, 16'h1234};
        req_len  = {2'd0, 2'd2};
        req      = 2'b01;
        for (int i = 0; i < 5 && byte_q.size() < 1; i++) step();
        for (int i = 0; i < 6; i++) step();
        total++; if (sched_busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b want 1", sched_busy); end
        RST = 1'b1;
        step();
        RST = 1'b0;
        total++; if (tx_data_valid !== 1'b0 || gnt !== 2'b00) begin bad++; $display("FAIL midrst_valid_gnt: got %b/%b want 0/00", tx_data_valid, gnt); end
        total++; if (tx_p_data !== 8'h00) begin bad++; $display("FAIL midrst_pdata: got %h want 00", tx_p_data); end
        total++; if (sched_busy !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("FAIL midrst_busy_done: got %b/%b want 0/0", sched_busy, frame_done); end
        for (int i = 0; i < 40; i++) step();
        total++; if (byte_q.size() != 1) begin bad++; $display("FAIL midrst_byte1_sent: got %0d bytes want 1", byte_q.size()); end
        total++; if (byte_q.size() >= 1 && byte_q[0] !== 8'h34) begin bad++; $display("FAIL midrst_byte0: got %h want 34", byte_q[0]); end
        total++; if (n_done != 0) begin bad++; $display("FAIL midrst_done: got %0d want 0", n_done); end
    endtask

    task automatic test_watchdog();
        do_reset();
        req_data = {16'h0000, 16'h00C3};
        req_len  = {2'd0, 2'd1};
        req      = 2'b01;
        step();
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL wd_err_early: got %b want 0", err_timeout); end
        for (int i = 0; i < 59; i++) step();
`ifdef UART_TX_SCHED_TIMEOUT_EN
        total++; if (valid_cyc_q.size() != 4) begin bad++; $display("FAIL wd_npulses: got %0d want 4", valid_cyc_q.size()); end
        for (int i = 1; i < 4 && i < valid_cyc_q.size(); i++) begin
            total++; if (valid_cyc_q[i] - valid_cyc_q[i-1] != 17) begin bad++; $display("FAIL wd_period%0d: got %0d want 17", i, valid_cyc_q[i] - valid_cyc_q[i-1]); end
            total++; if (byte_q[i] !== 8'hC3) begin bad++; $display("FAIL wd_byte%0d: got %h want c3", i, byte_q[i]); end
        end
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL wd_err_set: got %b want 1", err_timeout); end
`else
        total++; if (valid_cyc_q.size() != 1) begin bad++; $display("FAIL wd_npulses: got %0d want 1", valid_cyc_q.size()); end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL wd_err: got %b want 0", err_timeout); end
        total++; if (sched_busy !== 1'b1) begin bad++; $display("FAIL wd_still_waiting: got %b want 1", sched_busy); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_zero_len();
        test_pre_busy();
        test_reset_mid_frame();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
